// File: rtl/mem_dump_sequencer_pkg.sv
// Shared definitions for the data-memory dump path: FSM state encoding and
// word/byte geometry used by the sequencer and its serializer.
package mem_dump_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEF_MEM_ADDR_SIZE = 5;
    localparam int DEF_DATA_SIZE     = 32;
    localparam int BYTES_PER_WORD    = DEF_DATA_SIZE / 8;

    function automatic int bytes_per_word(input int data_size);
        return data_size / 8;
    endfunction

endpackage

// File: rtl/mem_dump_sequencer_if.sv
// Data-memory debug port and UART byte stream owned by the dump sequencer.
interface mem_dump_sequencer_if #(
    parameter int MEM_ADDR_SIZE = 5,
    parameter int DATA_SIZE     = 32
);
    logic                     o_debug_unit_flag;
    logic                     o_mem_read_enable;
    logic [MEM_ADDR_SIZE-1:0] o_mem_read_addr;
    logic [DATA_SIZE-1:0]     i_mem_read_data;
    logic [7:0]               o_tx_data;
    logic                     o_tx_valid;
    logic                     i_tx_ready;

    modport master (
        output o_debug_unit_flag, o_mem_read_enable, o_mem_read_addr,
        output o_tx_data, o_tx_valid,
        input  i_mem_read_data, i_tx_ready
    );

    modport slave (
        input  o_debug_unit_flag, o_mem_read_enable, o_mem_read_addr,
        input  o_tx_data, o_tx_valid,
        output i_mem_read_data, i_tx_ready
    );
endinterface

// File: rtl/word_serializer.sv
// Splits one captured memory word into bytes, LSB first, over a valid/ready
// handshake; flags the last byte so the sequencer knows when to move on.
module word_serializer
    import mem_dump_sequencer_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [DATA_SIZE-1:0] i_word,
    input  logic                 i_ready,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    output logic                 o_last
);
    localparam int BPW   = bytes_per_word(DATA_SIZE);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [DATA_SIZE-1:0] r_word;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_valid;

    assign o_data  = r_word[{r_idx, 3'b000} +: 8];
    assign o_valid = r_valid;
    assign o_last  = (r_idx == LAST_IDX);

    // Clear beats load so an abort in the capture cycle never starts a send.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            if (o_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_dump_sequencer.sv
// Walks every data-memory word while the pipeline is halted and streams it to
// the UART one byte at a time; owns the memory port for the whole dump.
module mem_dump_sequencer
    import mem_dump_sequencer_pkg::*;
#(
    parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
    parameter int DATA_SIZE     = DEF_DATA_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_pipeline_halted,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    mem_dump_sequencer_if.master bus
);
    localparam logic [MEM_ADDR_SIZE-1:0] LAST_ADDR = '1;

    state_t                   r_state;
    logic [MEM_ADDR_SIZE-1:0] r_addr;
    logic                     r_busy;
    logic                     r_mem_re;
    logic                     r_done;

    logic       w_load;
    logic       w_clear;
    logic       w_valid;
    logic       w_last;
    logic       w_hs;
    logic [7:0] w_tx_data;

    assign w_clear = i_abort && (r_state != ST_IDLE);
    assign w_load  = (r_state == ST_CAPTURE);
    assign w_hs    = w_valid && bus.i_tx_ready;

    word_serializer #(
        .DATA_SIZE (DATA_SIZE)
    ) u_ser (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_word  (bus.i_mem_read_data),
        .i_ready (bus.i_tx_ready),
        .o_data  (w_tx_data),
        .o_valid (w_valid),
        .o_last  (w_last)
    );

    assign bus.o_debug_unit_flag = r_busy;
    assign bus.o_mem_read_enable = r_mem_re;
    assign bus.o_mem_read_addr   = r_addr;
    assign bus.o_tx_data         = w_tx_data;
    assign bus.o_tx_valid        = w_valid;
    assign o_busy                = r_busy;
    assign o_done                = r_done;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_busy   <= 1'b0;
            r_mem_re <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_mem_re <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && i_pipeline_halted) begin
                        r_addr   <= '0;
                        r_state  <= ST_READ;
                        r_mem_re <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_READ:    r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_SEND;
                ST_SEND: begin
                    if (w_hs && w_last) begin
                        if (r_addr == LAST_ADDR) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr   <= r_addr + 1'b1;
                            r_state  <= ST_READ;
                            r_mem_re <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // Abort overrides whatever transition was chosen above.
            if (w_clear) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_mem_re <= 1'b0;
                r_done   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Directed bench for the memory dump sequencer: full dump, ignored start,
// back-pressure, abort/restart and asynchronous reset mid-dump.
module tb_mem_dump_sequencer;

    logic clk;
    logic rst;
    logic start;
    logic halted;
    logic abort;
    logic busy;
    logic done;

    int n_vec;
    int n_miss;
    int byte_cnt;
    int exp_addr;
    int done_cnt;
    logic prev_re;
    logic [31:0] mem [32];

    mem_dump_sequencer_if #(.MEM_ADDR_SIZE(5), .DATA_SIZE(32)) bus ();

    mem_dump_sequencer #(
        .MEM_ADDR_SIZE (5),
        .DATA_SIZE     (32)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_start           (start),
        .i_pipeline_halted (halted),
        .i_abort           (abort),
        .o_busy            (busy),
        .o_done            (done),
        .bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: synchronous read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.o_mem_read_enable) bus.i_mem_read_data <= mem[bus.o_mem_read_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_byte(input int k);
        logic [31:0] w;
        w = 32'hA0B0C000 + 32'(k / 4);
        return (w >> (8 * (k % 4))) & 32'h0000_00FF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        byte_cnt       = 0;
        exp_addr       = 0;
        done_cnt       = 0;
        bus.i_tx_ready = 1'b1;
        halted         = 1'b1;
        start          = 1'b1;
        tick();
        start  = 1'b0;
        halted = 1'b0;
    endtask

    task automatic run_to_done(input int max_cycles);
        int k;
        k = 0;
        while (done_cnt == 0 && k < max_cycles) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(k < max_cycles), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("idle_after", 32'(busy), 32'd0);
        chk("byte_total", 32'(byte_cnt), 32'd128);
        chk("addr_total", 32'(exp_addr), 32'd32);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_flag"}, 32'(bus.o_debug_unit_flag), 32'd0);
        chk({tag, "_re"},   32'(bus.o_mem_read_enable), 32'd0);
        chk({tag, "_addr"}, 32'(bus.o_mem_read_addr), 32'd0);
        chk({tag, "_valid"}, 32'(bus.o_tx_valid), 32'd0);
        chk({tag, "_data"}, 32'(bus.o_tx_data), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Protocol monitor: one-cycle strobes, ordered addresses, byte stream, done count.
    always @(negedge clk) begin
        if (bus.o_mem_read_enable) begin
            chk("re_pulse", 32'(prev_re), 32'd0);
            chk("re_addr", 32'(bus.o_mem_read_addr), 32'(exp_addr));
            exp_addr++;
        end
        prev_re = bus.o_mem_read_enable;
        if (bus.o_tx_valid && bus.i_tx_ready) begin
            chk("tx_byte", 32'(bus.o_tx_data), exp_byte(byte_cnt));
            byte_cnt++;
        end
        if (done) done_cnt++;
    end

    initial begin
        int k;
        n_vec = 0; n_miss = 0; byte_cnt = 0; exp_addr = 0; done_cnt = 0; prev_re = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA0B0C000 + 32'(i);
        rst = 1'b1; start = 1'b0; halted = 1'b0; abort = 1'b0; bus.i_tx_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk_all_zero("rst");
        tick();
        rst = 1'b0;

        // Start without a halted pipeline must be ignored.
        start = 1'b1; halted = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("nohalt_busy", 32'(busy), 32'd0);
            chk("nohalt_re", 32'(bus.o_mem_read_enable), 32'd0);
        end
        tick();
        start = 1'b0;

        // Full dump with ready tied high; halt drops after start and is ignored.
        start_dump();
        @(negedge clk);
        chk("lat_read_re", 32'(bus.o_mem_read_enable), 32'd1);
        chk("lat_read_busy", 32'(busy), 32'd1);
        chk("lat_read_valid", 32'(bus.o_tx_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_cap_valid", 32'(bus.o_tx_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_send_valid", 32'(bus.o_tx_valid), 32'd1);
        chk("lat_send_data", 32'(bus.o_tx_data), 32'h00);
        run_to_done(400);

        // Back-pressure on byte 2 of word 7.
        start_dump();
        k = 0;
        while (byte_cnt != 30 && k < 300) begin
            tick();
            k++;
        end
        chk("stall_reach", 32'(byte_cnt), 32'd30);
        bus.i_tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_data", 32'(bus.o_tx_data), 32'hB0);
            chk("stall_valid", 32'(bus.o_tx_valid), 32'd1);
            chk("stall_addr", 32'(bus.o_mem_read_addr), 32'd7);
            tick();
        end
        bus.i_tx_ready = 1'b1;
        run_to_done(400);

        // Abort while sending word 10, then restart from address 0.
        start_dump();
        k = 0;
        while (!(bus.o_mem_read_addr == 5'd10 && bus.o_tx_valid) && k < 300) begin
            tick();
            k++;
        end
        chk("abort_reach", 32'(k < 300), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(bus.o_tx_valid), 32'd0);
        chk("abort_flag", 32'(bus.o_debug_unit_flag), 32'd0);
        chk("abort_bytes", 32'(byte_cnt), 32'd41);
        repeat (4) tick();
        chk("abort_nodone", 32'(done_cnt), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        start_dump();
        run_to_done(400);

        // Asynchronous reset between edges mid-dump.
        start_dump();
        k = 0;
        while (byte_cnt != 20 && k < 300) begin
            tick();
            k++;
        end
        chk("rst_reach", 32'(byte_cnt), 32'd20);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_stay_idle", 32'(busy), 32'd0);
        chk("rst_nodone", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_dump_sequencer.md
MEM_DUMP_SEQUENCER -- requirements
Module: mem_dump_sequencer

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_SIZE, default 5, giving the data-memory word-address width.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32, giving the memory word width; it must be a multiple of 8.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  system clock; all state changes on the rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  dump request from the debug unit, sampled only in IDLE.
REQ-007 i_pipeline_halted  input  1  high when the pipeline is stalled and issues no memory accesses.
REQ-008 i_abort  input  1  synchronous cancel of a dump in progress.
REQ-009 o_debug_unit_flag  output  1  gives data-memory port ownership to the debug path.
REQ-010 o_mem_read_enable  output  1  debug read strobe to the data memory.
REQ-011 o_mem_read_addr  output  MEM_ADDR_SIZE  debug read word address.
REQ-012 i_mem_read_data  input  DATA_SIZE  memory read data, valid one cycle after the strobe.
REQ-013 o_tx_data  output  8  byte to the UART transmitter.
REQ-014 o_tx_valid  output  1  o_tx_data is valid.
REQ-015 i_tx_ready  input  1  the transmitter accepts the byte this cycle.
REQ-016 o_busy  output  1  a dump is in progress.
REQ-017 o_done  output  1  one-cycle pulse when the last byte has been accepted.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, READ, CAPTURE, SEND and DONE.
REQ-019 IDLE: on i_start=1 and i_pipeline_halted=1, the block SHALL clear the address to 0 and go to READ; otherwise it SHALL ignore i_start.
REQ-020 READ: the block SHALL assert o_mem_read_enable=1 with o_mem_read_addr equal to the current address for exactly one cycle, then go to CAPTURE.
REQ-021 CAPTURE: the block SHALL register i_mem_read_data into a word buffer, clear the byte index, and go to SEND.
REQ-022 SEND: the block SHALL drive o_tx_valid=1 and o_tx_data=word[8*idx+7:8*idx], sending bytes LSB first.
REQ-023 In SEND, o_tx_data and o_tx_valid SHALL stay stable until a cycle with o_tx_valid and i_tx_ready both high (handshake).
REQ-024 On a handshake with idx < DATA_SIZE/8-1, the block SHALL increment idx.
REQ-025 On a handshake at the last byte, the block SHALL go to DONE if the address equals 2^MEM_ADDR_SIZE-1; otherwise it SHALL increment the address and go to READ.
REQ-026 The address SHALL NOT wrap; the dump covers exactly 2^MEM_ADDR_SIZE words and (2^MEM_ADDR_SIZE)*DATA_SIZE/8 bytes.
REQ-027 DONE: the block SHALL assert o_done=1 for one cycle, then go to IDLE.
REQ-028 o_debug_unit_flag and o_busy SHALL be 1 in READ, CAPTURE, SEND and DONE, and 0 in IDLE.
REQ-029 o_mem_read_enable SHALL be 1 only in READ; o_tx_valid SHALL be 1 only in SEND.
REQ-030 i_abort=1 in any non-IDLE state SHALL move the block to IDLE on the next edge with no o_done pulse; a byte handshaking in the same cycle counts as sent.
REQ-031 i_abort SHALL take priority over every other transition; i_abort in IDLE has no effect.
REQ-032 If i_pipeline_halted falls during a dump, the block SHALL continue the dump; the halt is checked only at start.
REQ-033 Latency from an accepted i_start to the first o_tx_valid SHALL be 3 cycles (READ, CAPTURE, SEND).

Reset
REQ-034 While i_reset=1, the block SHALL force state=IDLE, and address, byte index, word buffer and every output to 0, asynchronously.
REQ-035 Reset during a dump SHALL abandon it with no o_done pulse; a new dump needs a fresh i_start.

Structure
REQ-036 The state encodings and localparam BYTES_PER_WORD = DATA_SIZE/8 SHALL live in the shared debug package.
REQ-037 Byte indexing and the tx handshake SHALL be one sub-module, word_serializer (load, word in, valid/ready out, last-byte flag).
REQ-038 The FSM and address counter SHALL stay in mem_dump_sequencer, whose outputs drive the data-memory port-select logic.

Verification
REQ-039 With i_tx_ready tied to 1, memory word n = 0xA0B0C000+n, and a start pulse, the bench SHALL see 128 bytes 00,C0,B0,A0,01,C0,... then exactly one o_done.
REQ-040 With i_start=1 and i_pipeline_halted=0, the bench SHALL see the block stay in IDLE with o_busy=0 and o_mem_read_enable never 1.
REQ-041 With i_tx_ready low for 5 cycles during byte 2 of word 7, o_tx_data SHALL hold 0xB0 and o_mem_read_addr SHALL stay at 7.
REQ-042 With i_abort asserted at word 10 in SEND, the next cycle SHALL show o_busy=0, o_tx_valid=0 and no o_done; a new start SHALL restart at address 0.
REQ-043 With i_reset asserted mid-dump between clock edges, all outputs SHALL go to 0 immediately, before the next edge.
REQ-044 The bench SHALL check that every o_mem_read_enable pulse lasts one cycle and that addresses run 0..31 in order with no repeats.
